// File: rtl/av2_recon_wb_packer_if.sv
// Reconstruction write-back bus bundle.
// Carries the upstream pixel beat stream (s_pix_*) and the frame-buffer
// single-outstanding write request port (fb_wr_*).
//   master : the environment side (pixel producer + frame-buffer controller)
//   slave  : the packer block
interface av2_recon_wb_packer_if #(
    parameter int IN_WIDTH   = 64,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic [IN_WIDTH-1:0]   s_pix_data;
    logic                  s_pix_valid;
    logic                  s_pix_ready;
    logic                  s_pix_last;
    logic [ADDR_WIDTH-1:0] fb_wr_addr;
    logic [DATA_WIDTH-1:0] fb_wr_data;
    logic                  fb_wr_en;
    logic                  fb_wr_done;

    modport master (
        output s_pix_data, s_pix_valid, s_pix_last, fb_wr_done,
        input  s_pix_ready, fb_wr_addr, fb_wr_data, fb_wr_en
    );

    modport slave (
        input  s_pix_data, s_pix_valid, s_pix_last, fb_wr_done,
        output s_pix_ready, fb_wr_addr, fb_wr_data, fb_wr_en
    );
endinterface

// File: rtl/av2_recon_wb_packer.sv
// Reconstruction write-back packer.
// Packs IN_WIDTH pixel beats into DATA_WIDTH frame-buffer words (lane 0 in
// the LSBs), queues them in a small FIFO and issues them as raster-addressed
// single writes, one outstanding at a time.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame start pulse, honoured only in IDLE
//   base_addr   : frame base byte address, latched on accepted start
//   bus         : pixel stream in + frame-buffer write port (slave side)
//   busy        : high whenever the frame FSM is not IDLE
//   frame_done  : one-cycle pulse after the last word's write completes
//   word_count  : words issued in the current frame
module av2_recon_wb_packer #(
    parameter int DATA_WIDTH = 128,
    parameter int IN_WIDTH   = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    av2_recon_wb_packer_if.slave  bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           word_count
);
    localparam int R  = DATA_WIDTH / IN_WIDTH;
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BPW = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                        r_state, w_state_nxt;
    logic [LW-1:0]                 r_lane;
    logic [R-1:0][IN_WIDTH-1:0]    r_pack, w_pack_nxt;
    logic [DATA_WIDTH-1:0]         r_fifo [FIFO_DEPTH];
    logic [PW-1:0]                 r_wp, r_rp;
    logic [PW:0]                   r_cnt;
    logic                          r_outst;
    logic [ADDR_WIDTH-1:0]         r_base, r_widx, r_wr_addr;
    logic [DATA_WIDTH-1:0]         r_wr_data;
    logic                          r_wr_en;
    logic [31:0]                   r_wcnt;
    logic                          w_full, w_empty, w_start, w_ready;
    logic                          w_acc, w_push, w_pop;

    assign w_full  = (r_cnt == (PW+1)'(FIFO_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_start = (r_state == S_IDLE) && start;
    assign w_acc   = w_ready && bus.s_pix_valid;
    // A word closes on its last lane or early on the frame's final beat.
    assign w_push  = w_acc && ((r_lane == LW'(R-1)) || bus.s_pix_last);
    assign w_pop   = !r_outst && !w_empty;

    // Current beat merged into the pack register; pushed as-is on w_push.
    always_comb begin
        w_pack_nxt         = r_pack;
        w_pack_nxt[r_lane] = bus.s_pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        frame_done  = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                w_ready = !w_full;
                if (w_acc && bus.s_pix_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_empty && !r_outst) w_state_nxt = S_DONE;
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage needs no reset: pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= w_pack_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane    <= '0;
            r_pack    <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_outst   <= 1'b0;
            r_base    <= '0;
            r_widx    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_start) begin
                r_base <= base_addr;
                r_lane <= '0;
                r_pack <= '0;
                r_widx <= '0;
                r_wcnt <= '0;
            end else if (w_acc) begin
                if (w_push) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + LW'(1);
                    r_pack <= w_pack_nxt;
                end
            end
            if (w_push) r_wp <= r_wp + PW'(1);
            // Issue: address/data held in registers until the next pop,
            // so they stay stable across the whole outstanding window.
            if (w_pop) begin
                r_wr_data <= r_fifo[r_rp];
                r_wr_addr <= r_base + r_widx * BPW;
                r_widx    <= r_widx + ADDR_WIDTH'(1);
                r_wcnt    <= r_wcnt + 32'd1;
                r_rp      <= r_rp + PW'(1);
                r_outst   <= 1'b1;
            end else if (bus.fb_wr_done) begin
                r_outst   <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.s_pix_ready = w_ready;
    assign bus.fb_wr_addr  = r_wr_addr;
    assign bus.fb_wr_data  = r_wr_data;
    assign bus.fb_wr_en    = r_wr_en;
    assign word_count      = r_wcnt;
endmodule

// File: tb/tb_av2_recon_wb_packer.sv
// Bench for av2_recon_wb_packer: table of frames plus hand sequences for
// backpressure, spurious done and mid-frame reset. A reference packer model
// pushes expected writes into a queue on each accepted beat; the responder
// pops and compares on every fb_wr_en and returns fb_wr_done.
module tb_av2_recon_wb_packer;
    localparam int DW = 128, IW = 64, AW = 32, FD = 4;
    localparam int R  = DW / IW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        int          nb;
        int          dly;
        bit          mid;
        int          exp_w;
        logic [31:0] exp_last;
    } vec_t;

    logic          clk = 0, rst_n = 0, start = 0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, frame_done;
    logic [31:0]   word_count;

    av2_recon_wb_packer_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    av2_recon_wb_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .bus(bus), .busy(busy), .frame_done(frame_done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    wr_t q[$];
    int fd_cnt = 0, wr_seen = 0;
    logic [31:0] last_addr = '0;
    int resp_dly = 3;
    bit resp_stall = 0;
    int spur_req = 0, spur_ack = 0;

    // reference packer state
    logic [31:0]             m_base;
    int                      m_idx, m_lane, m_acc;
    logic [R-1:0][IW-1:0]    m_pack;
    int fd0, w0;
    bit tx_busy = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge clk) if (frame_done) fd_cnt++;

    // Downstream frame-buffer responder / scoreboard consumer.
    logic [AW-1:0] r_ca;
    logic [DW-1:0] r_cd;
    bit            r_st;
    int            r_t;
    wr_t           r_e;
    initial begin
        bus.fb_wr_done = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.fb_wr_en) begin
                wr_seen++;
                r_ca = bus.fb_wr_addr;
                r_cd = bus.fb_wr_data;
                last_addr = r_ca;
                if (q.size() == 0) fail("unexpected_write");
                else begin
                    r_e = q.pop_front();
                    chk("wr_addr", 128'(r_ca), 128'(r_e.addr));
                    chk("wr_data", r_cd, r_e.data);
                end
                r_st = 1;
                r_t  = 0;
                while ((r_t < resp_dly || resp_stall) && rst_n) begin
                    @(negedge clk);
                    r_t++;
                    if (rst_n && (bus.fb_wr_addr !== r_ca || bus.fb_wr_data !== r_cd || bus.fb_wr_en !== 1'b0))
                        r_st = 0;
                end
                if (rst_n) begin
                    chk("wr_stable", 128'(r_st), 128'(1));
                    bus.fb_wr_done = 1;
                    @(negedge clk);
                    bus.fb_wr_done = 0;
                end
            end else if (spur_req != spur_ack) begin
                bus.fb_wr_done = 1;
                @(negedge clk);
                bus.fb_wr_done = 0;
                spur_ack++;
            end
        end
    end

    task automatic model_accept(input logic [IW-1:0] d, input bit last);
        m_acc++;
        m_pack[m_lane] = d;
        if (m_lane == R - 1 || last) begin
            q.push_back('{addr: m_base + 32'(m_idx) * 32'(DW / 8), data: m_pack});
            m_idx++;
            m_pack = '0;
            m_lane = 0;
        end else m_lane++;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_beat(input logic [IW-1:0] d, input bit last);
        int t = 0;
        bus.s_pix_data  = d;
        bus.s_pix_last  = last;
        bus.s_pix_valid = 1;
        #1;
        while (!bus.s_pix_ready && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.s_pix_ready) fail("beat_accept");
        else begin
            @(posedge clk);
            model_accept(d, last);
        end
        @(negedge clk);
        bus.s_pix_valid = 0;
        bus.s_pix_last  = 0;
    endtask

    task automatic send_beats(input int n, input bit mid);
        for (int i = 0; i < n; i++) begin
            if (mid && i == 1) begin
                start     = 1;
                base_addr = 32'hDEAD_0000;
                @(negedge clk);
                start     = 0;
            end
            send_beat({$urandom, $urandom}, i == n - 1);
        end
        tx_busy = 0;
    endtask

    task automatic start_frame(input logic [31:0] base);
        m_base = base; m_idx = 0; m_lane = 0; m_acc = 0; m_pack = '0;
        fd0 = fd_cnt; w0 = wr_seen;
        start = 1; base_addr = base;
        @(negedge clk);
        start = 0; base_addr = '0;
    endtask

    task automatic finish_frame(input string tag, input int exp_w, input logic [31:0] exp_last);
        int t = 0;
        while (fd_cnt == fd0 && t < 1000) begin @(negedge clk); t++; end
        if (fd_cnt == fd0) fail({tag, "_frame_done_wait"});
        repeat (2) @(negedge clk);
        chk({tag, "_frame_done_pulses"}, 128'(fd_cnt - fd0), 128'(1));
        chk({tag, "_busy_after"}, 128'(busy), 128'(0));
        chk({tag, "_word_count"}, 128'(word_count), 128'(exp_w));
        chk({tag, "_writes"}, 128'(wr_seen - w0), 128'(exp_w));
        chk({tag, "_last_addr"}, 128'(last_addr), 128'(exp_last));
        chk({tag, "_queue_empty"}, 128'(q.size()), 128'(0));
    endtask

    vec_t vt[5];

    initial begin
        int t;
        vt[0] = '{32'h0000_1000, 4, 3, 0, 2, 32'h0000_1010};
        vt[1] = '{32'h0000_2000, 3, 3, 0, 2, 32'h0000_2010};
        vt[2] = '{32'h0000_3000, 5, 0, 1, 3, 32'h0000_3020};
        vt[3] = '{32'hFFFF_FFF0, 4, 1, 0, 2, 32'h0000_0000};
        vt[4] = '{32'h0000_0040, 1, 2, 0, 1, 32'h0000_0040};

        bus.s_pix_data = '0; bus.s_pix_valid = 0; bus.s_pix_last = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(bus.s_pix_ready), 128'(0));
        chk("rst_wr_en", 128'(bus.fb_wr_en), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        chk("rst_addr", 128'(bus.fb_wr_addr), 128'(0));
        chk("rst_data", bus.fb_wr_data, 128'(0));
        chk("rst_word_count", 128'(word_count), 128'(0));
        rst_n = 1;
        repeat (2) @(negedge clk);

        // spurious done while idle is ignored
        spur_req++;
        repeat (3) @(negedge clk);
        chk("spur_busy", 128'(busy), 128'(0));
        chk("spur_wr_en", 128'(bus.fb_wr_en), 128'(0));

        foreach (vt[i]) begin
            resp_dly = vt[i].dly;
            start_frame(vt[i].base);
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(1));
            send_beats(vt[i].nb, vt[i].mid);
            finish_frame($sformatf("v%0d", i), vt[i].exp_w, vt[i].exp_last);
        end

        // Backpressure: downstream stalled, 20 beats offered.
        resp_dly = 1; resp_stall = 1;
        start_frame(32'h0000_5000);
        tx_busy = 1;
        fork send_beats(20, 0); join_none
        repeat (30) @(negedge clk);
        #1;
        chk("bp_ready_low", 128'(bus.s_pix_ready), 128'(0));
        chk("bp_beats_accepted", 128'(m_acc), 128'(FD * R + R));
        repeat (10) @(negedge clk);
        resp_stall = 0;
        t = 0;
        while (tx_busy && t < 2000) begin @(negedge clk); t++; end
        if (tx_busy) fail("bp_stream_wait");
        finish_frame("bp", 10, 32'h0000_5000 + 9 * 16);

        // Reset in DRAIN with a write outstanding.
        resp_dly = 1; resp_stall = 1;
        start_frame(32'h0000_6000);
        send_beats(2, 0);
        t = 0;
        while (wr_seen == w0 && t < 100) begin @(negedge clk); t++; end
        if (wr_seen == w0) fail("rd_write_wait");
        @(negedge clk);
        chk("rd_busy_before", 128'(busy), 128'(1));
        #2 rst_n = 0;
        #1;
        chk("rd_ready", 128'(bus.s_pix_ready), 128'(0));
        chk("rd_wr_en", 128'(bus.fb_wr_en), 128'(0));
        chk("rd_busy", 128'(busy), 128'(0));
        chk("rd_frame_done", 128'(frame_done), 128'(0));
        chk("rd_addr", 128'(bus.fb_wr_addr), 128'(0));
        chk("rd_data", bus.fb_wr_data, 128'(0));
        chk("rd_word_count", 128'(word_count), 128'(0));
        q.delete();
        resp_stall = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        resp_dly = 2;
        start_frame(32'h0000_7000);
        send_beats(4, 0);
        finish_frame("post_rst", 2, 32'h0000_7010);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog");
    end
endmodule
